// File: rtl/avalon_st_pkt_pkg.sv
// Shared types and constants for the Avalon-ST packetizer.
// Optional feature macro: AVALON_ST_PACKETIZER_CHECKSUM_EN adds the CHECKSUM state.
package avalon_st_pkt_pkg;

  localparam int         SEQ_W     = 4;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
    , CHECKSUM = 2'd3
`endif
  } pkt_state_t;

  // Header byte: sequence number in the upper nibble, magic in the lower.
  function automatic logic [7:0] hdr_byte(input logic [SEQ_W-1:0] seq);
    return {seq, HDR_MAGIC};
  endfunction

endpackage

// File: rtl/avalon_st_out_reg.sv
// One-entry Avalon-ST output register (data, SOP, EOP) with slot-free signal.
// A loaded beat is held stable until the sink accepts it; a load in the same
// cycle as a handshake replaces the departing beat without a bubble.
module avalon_st_out_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       sop_i,
  input  logic       eop_i,
  input  logic       ready_i,
  output logic       free_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       sop_o,
  output logic       eop_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       sop_q;
  logic       eop_q;

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign free_o = !valid_q || ready_i;

  // Beat register: load wins, otherwise drop valid after a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (load_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q <= 1'b1;
      data_q  <= data_i;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/avalon_st_packetizer.sv
// Frames an unframed byte stream into fixed-length Avalon-ST packets:
// header {seq,4'hA} with SOP, PKT_LEN payload bytes, optional XOR checksum.
// Optional feature macro: AVALON_ST_PACKETIZER_CHECKSUM_EN (EOP moves to the
// appended checksum beat; otherwise EOP sits on the last payload byte).
module avalon_st_packetizer
  import avalon_st_pkt_pkg::*;
#(
  parameter int PKT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       asi_valid,
  input  logic [7:0] asi_data,
  output logic       asi_ready,
  output logic       aso_valid,
  output logic [7:0] aso_data,
  output logic       aso_startofpacket,
  output logic       aso_endofpacket,
  input  logic       aso_ready
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  pkt_state_t       state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [7:0]       cnt_q, cnt_d;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic       slot_free;
  logic       ld;
  logic [7:0] ld_data;
  logic       ld_sop;
  logic       ld_eop;

  // State, sequence, counter (and checksum) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= '0;
      cnt_q   <= 8'h00;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state logic and output-slot load requests.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    seq_d     = seq_q;
    cnt_d     = cnt_q;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    asi_ready = 1'b0;
    ld        = 1'b0;
    ld_data   = 8'h00;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing is consumed here, so a packet never opens without data.
        if (asi_valid) state_d = HEADER;
      end

      HEADER: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = hdr_byte(seq_q);
          ld_sop  = 1'b1;
          cnt_d   = 8'h00;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = PAYLOAD;
        end
      end

      PAYLOAD: begin
        asi_ready = slot_free;
        if (asi_valid && slot_free) begin
          ld      = 1'b1;
          ld_data = asi_data;
          cnt_d   = cnt_q + 8'd1;
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
          csum_d  = csum_q ^ asi_data;
          if (cnt_q == LAST_IDX) state_d = CHECKSUM;
`else
          if (cnt_q == LAST_IDX) begin
            ld_eop  = 1'b1;
            seq_d   = seq_q + 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end

`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
      CHECKSUM: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = csum_q;
          ld_eop  = 1'b1;
          seq_d   = seq_q + 1'b1;
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  avalon_st_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ld),
    .data_i  (ld_data),
    .sop_i   (ld_sop),
    .eop_i   (ld_eop),
    .ready_i (aso_ready),
    .free_o  (slot_free),
    .valid_o (aso_valid),
    .data_o  (aso_data),
    .sop_o   (aso_startofpacket),
    .eop_o   (aso_endofpacket)
  );

endmodule

// File: tb/tb_avalon_st_packetizer.sv
// Scoreboard bench for avalon_st_packetizer (PKT_LEN=4). Expected beats are
// queued when a packet is issued; a monitor pops them on every handshake.
// Handles both builds of AVALON_ST_PACKETIZER_CHECKSUM_EN.
module tb_avalon_st_packetizer;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       asi_valid;
  logic [7:0] asi_data;
  logic       asi_ready;
  logic       aso_valid;
  logic [7:0] aso_data;
  logic       aso_startofpacket;
  logic       aso_endofpacket;
  logic       aso_ready;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic [3:0] seq_m = 4'h0;
  bit    rand_ready = 1'b0;
  int    low_left = 0;

  always #5 clk = ~clk;

  avalon_st_packetizer #(.PKT_LEN(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .asi_valid         (asi_valid),
    .asi_data          (asi_data),
    .asi_ready         (asi_ready),
    .aso_valid         (aso_valid),
    .aso_data          (aso_data),
    .aso_startofpacket (aso_startofpacket),
    .aso_endofpacket   (aso_endofpacket),
    .aso_ready         (aso_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: steady 1, or random low bursts of 1..5 cycles.
  always @(negedge clk) begin
    if (!rand_ready) begin
      aso_ready = 1'b1;
      low_left  = 0;
    end else if (low_left > 0) begin
      aso_ready = 1'b0;
      low_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      aso_ready = 1'b0;
      low_left  = int'($urandom_range(1, 5)) - 1;
    end else begin
      aso_ready = 1'b1;
    end
  end

  // Monitor: outputs are sampled mid-low-phase, so the values seen are the
  // ones presented at the coming rising edge.
  beat_t held;
  bit    prev_stall = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", aso_valid, 1);
        check("hold_beat", {aso_data, aso_startofpacket, aso_endofpacket}, held);
      end
      if (aso_valid && !aso_ready) check("asi_ready_while_full", asi_ready, 0);
      if (aso_valid && aso_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h sop %0b eop %0b expected none",
                   aso_data, aso_startofpacket, aso_endofpacket);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", aso_data, e.d);
          check("beat_sop", aso_startofpacket, e.sop);
          check("beat_eop", aso_endofpacket, e.eop);
        end
      end
      prev_stall = aso_valid && !aso_ready;
      held = {aso_data, aso_startofpacket, aso_endofpacket};
    end
  end

  // Queue the expected framing for one packet and advance the model sequence.
  task automatic push_pkt(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] b[4];
    logic [7:0] cs;
    b = '{b0, b1, b2, b3};
    cs = 8'h00;
    exp_q.push_back('{d: {seq_m, 4'hA}, sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < 4; i++) begin
      cs ^= b[i];
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
      exp_q.push_back('{d: b[i], sop: 1'b0, eop: 1'b0});
`else
      exp_q.push_back('{d: b[i], sop: 1'b0, eop: (i == 3)});
`endif
    end
`ifdef AVALON_ST_PACKETIZER_CHECKSUM_EN
    exp_q.push_back('{d: cs, sop: 1'b0, eop: 1'b1});
`endif
    seq_m = seq_m + 4'h1;
  endtask

  // Present one byte until accepted (bounded), returning just after the edge.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    asi_valid = 1'b1;
    asi_data  = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      #1;
      acc = asi_ready;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted within 300 cycles", b);
    end
    @(posedge clk);
    #1;
    asi_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
    push_pkt(b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aso_valid"}, aso_valid, 0);
    check({tag, "_aso_data"}, aso_data, 8'h00);
    check({tag, "_sop"}, aso_startofpacket, 0);
    check({tag, "_eop"}, aso_endofpacket, 0);
    check({tag, "_asi_ready"}, asi_ready, 0);
  endtask

  initial begin
    reset     = 1'b1;
    asi_valid = 1'b0;
    asi_data  = 8'h00;
    aso_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two back-to-back packets with steady downstream ready.
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04);
    send_pkt(8'h10, 8'h20, 8'h30, 8'h40);
    drain();

    // Downstream backpressure in random bursts.
    rand_ready = 1'b1;
    send_pkt(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    send_pkt(8'h55, 8'hAA, 8'h00, 8'hFF);
    send_pkt(8'h80, 8'h7F, 8'h01, 8'hFE);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ten-cycle upstream gap mid-payload: packet stalls without EOP.
    push_pkt(8'h11, 8'h22, 8'h33, 8'h44);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (10) @(posedge clk);
    #1;
    check("gap_no_eop", aso_endofpacket, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    drain();

    // Reset after two payload bytes: only header and first byte get out.
    exp_q.push_back('{d: {seq_m, 4'hA}, sop: 1'b1, eop: 1'b0});
    exp_q.push_back('{d: 8'h01, sop: 1'b0, eop: 1'b0});
    send_byte(8'h01);
    send_byte(8'h02);
    check("pre_reset_valid", aso_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    check("abort_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    seq_m = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Seventeen packets from seq 0: headers 0A..FA then 0A again.
    for (int i = 0; i < 17; i++) begin
      send_pkt(8'(i), 8'(i + 1), 8'(8'hF0 ^ i), 8'(i * 3));
    end
    check("seq_wrapped_model", seq_m, 4'h1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
